// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step sequencer: freezes F/D and bubbles E, then drains E/M/W (DRAIN_CYC cycles) before HALT.
// Breakpoint freeze is combinational; perf counters issue_cnt/cycle_cnt exist only with PIPE_RUN_CTRL_PERF_EN.
module pipe_run_ctrl #(
  parameter bit BOOT_RUN  = 1'b1,
  parameter int STEP_W    = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc_d,
  input  logic              d_vld,
  input  logic              issue_vld,
  input  logic              br_sel_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              halted,
  output logic              bp_hit,
  output logic [31:0]       issue_cnt,
  output logic [31:0]       cycle_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;
  localparam logic [1:0] S_BOOT  = BOOT_RUN ? S_RUN : S_HALT;

  localparam int              DW       = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0]   DRAIN_LD = DW'(DRAIN_CYC);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DW-1:0]     drain_cnt;
  logic [STEP_W-1:0] step_left;
  logic              halt_pend;
  logic              bp_skip;

  logic active;
  logic bp_match;
  logic freeze;
  logic halt_go;
  logic step_done;
  logic resume;

  assign active   = (state == S_RUN) || (state == S_STEP);
  assign bp_match = bp_en && d_vld && (pc_d == bp_addr) && !bp_skip && !br_sel_e && active;
  assign freeze   = (state == S_DRAIN) || (state == S_HALT) || bp_match;

  assign stall_f  = freeze;
  assign stall_d  = freeze;
  assign flush_e  = freeze;
  assign halted   = (state == S_HALT);

  // A redirect in E must land in F before the front end is frozen.
  assign halt_go  = (halt_pend || halt_req) && !br_sel_e;

  // step_left == 0 in STEP means the last instruction issued under a redirect.
  assign step_done = (state == S_STEP) && !br_sel_e &&
                     ((issue_vld && (step_left == STEP_ONE)) || (step_left == '0));

  assign resume   = (state == S_HALT) && (step_req || run_req);

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN, S_STEP: begin
        if (halt_go || bp_match || step_done) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt <= DW'(1)) begin
          state_nxt = S_HALT;
        end
      end
      default: begin
        if (step_req) begin
          state_nxt = S_STEP;
        end else if (run_req) begin
          state_nxt = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_BOOT;
      drain_cnt <= '0;
      step_left <= '0;
      halt_pend <= 1'b0;
      bp_skip   <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state != S_DRAIN) && (state_nxt == S_DRAIN)) begin
        drain_cnt <= DRAIN_LD;
      end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DW'(1);
      end

      if (!active || (state_nxt == S_DRAIN)) begin
        halt_pend <= 1'b0;
      end else if (halt_req) begin
        halt_pend <= 1'b1;
      end

      if ((state == S_HALT) && step_req) begin
        step_left <= (step_cnt == '0) ? STEP_ONE : step_cnt;
      end else if ((state == S_STEP) && issue_vld && (step_left != '0)) begin
        step_left <= step_left - STEP_ONE;
      end

      // Resuming from a breakpoint PC must let that instruction issue once.
      if (resume) begin
        bp_skip <= 1'b1;
      end else if (active && issue_vld) begin
        bp_skip <= 1'b0;
      end

      if (resume) begin
        bp_hit <= 1'b0;
      end else if (bp_match) begin
        bp_hit <= 1'b1;
      end
    end
  end

`ifdef PIPE_RUN_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (issue_vld) begin
        issue_cnt <= issue_cnt + 32'd1;
      end
      if (active) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end
`else
  assign issue_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: vector table per scenario plus a small front-end model (PC/D register, branch redirect).
module tb_pipe_run_ctrl;

`ifdef PIPE_RUN_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] BP_PC  = 32'h40;
  localparam logic [31:0] BR_TGT = 32'h200;

  localparam logic [5:0] C_RST  = 6'b100000;
  localparam logic [5:0] C_RUN  = 6'b010000;
  localparam logic [5:0] C_HALT = 6'b001000;
  localparam logic [5:0] C_STEP = 6'b000100;
  localparam logic [5:0] C_BR   = 6'b000010;
  localparam logic [5:0] C_HZ   = 6'b000001;
  localparam logic [5:0] C_NONE = 6'b000000;

  // expected {freeze, halted, bp_hit}
  localparam logic [2:0] E_RUN  = 3'b000;
  localparam logic [2:0] E_FRZ  = 3'b100;
  localparam logic [2:0] E_HALT = 3'b110;
  localparam logic [2:0] E_BPD  = 3'b101;
  localparam logic [2:0] E_BPH  = 3'b111;

  typedef struct {
    int         seg;
    logic [5:0] ctl;
    logic [7:0] cnt;
    logic [2:0] ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, run_req, halt_req, step_req, bp_en, d_vld, issue_vld, br_sel_e;
  logic [7:0]  step_cnt;
  logic [31:0] bp_addr, pc_d, pc_nxt;
  logic        hz_stall, fz;

  logic        stall_f0, stall_d0, flush_e0, halted0, bp_hit0;
  logic [31:0] issue_cnt0, cycle_cnt0;
  logic        stall_f1, stall_d1, flush_e1, halted1, bp_hit1;
  logic [31:0] issue_cnt1, cycle_cnt1;

  vec_t       tab[$];
  logic [2:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_iss = 0;
  int         n_bp_iss = 0;
  int         n0;

  pipe_run_ctrl #(.BOOT_RUN(1'b1), .STEP_W(8), .DRAIN_CYC(3)) u0 (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr), .pc_d(pc_d), .d_vld(d_vld),
    .issue_vld(issue_vld), .br_sel_e(br_sel_e), .stall_f(stall_f0), .stall_d(stall_d0),
    .flush_e(flush_e0), .halted(halted0), .bp_hit(bp_hit0), .issue_cnt(issue_cnt0),
    .cycle_cnt(cycle_cnt0)
  );

  pipe_run_ctrl #(.BOOT_RUN(1'b0), .STEP_W(8), .DRAIN_CYC(3)) u1 (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr), .pc_d(pc_d), .d_vld(d_vld),
    .issue_vld(issue_vld), .br_sel_e(br_sel_e), .stall_f(stall_f1), .stall_d(stall_d1),
    .flush_e(flush_e1), .halted(halted1), .bp_hit(bp_hit1), .issue_cnt(issue_cnt1),
    .cycle_cnt(cycle_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int seg, input logic [5:0] ctl, input logic [7:0] cnt,
                              input logic [2:0] ex);
    vec_t v;
    v.seg = seg;
    v.ctl = ctl;
    v.cnt = cnt;
    v.ex  = ex;
    tab.push_back(v);
  endfunction

  // Drive one cycle's inputs; the core only issues when D is real and nobody stalls/flushes it.
  task automatic drive(input logic [5:0] ctl, input logic [7:0] cnt);
    rst      = ctl[5];
    run_req  = ctl[4];
    halt_req = ctl[3];
    step_req = ctl[2];
    br_sel_e = ctl[1];
    hz_stall = ctl[0];
    step_cnt = cnt;
    #1;
    issue_vld = d_vld && !stall_d0 && !hz_stall && !br_sel_e;
  endtask

  task automatic end_cyc();
    fz = stall_d0;
    if (issue_vld) begin
      n_iss++;
      if (pc_d == BP_PC) n_bp_iss++;
    end
    @(posedge clk);
    #1;
    if (br_sel_e) begin
      d_vld  = 1'b0;
      pc_nxt = BR_TGT;
    end else if (!fz && !hz_stall) begin
      pc_d   = pc_nxt;
      d_vld  = 1'b1;
      pc_nxt = pc_nxt + 32'd4;
    end
    rst = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    br_sel_e = 1'b0; hz_stall = 1'b0; issue_vld = 1'b0;
  endtask

  task automatic run_tab(input int seg);
    logic [2:0] e;
    int k;
    k = 0;
    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].seg == seg) begin
        drive(tab[i].ctl, tab[i].cnt);
        exp_q.push_back(tab[i].ex);
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("s%0d[%0d] stall_f", seg, k), 32'(stall_f0), 32'(e[2]));
        check($sformatf("s%0d[%0d] stall_d", seg, k), 32'(stall_d0), 32'(e[2]));
        check($sformatf("s%0d[%0d] flush_e", seg, k), 32'(flush_e0), 32'(e[2]));
        check($sformatf("s%0d[%0d] halted", seg, k), 32'(halted0), 32'(e[1]));
        check($sformatf("s%0d[%0d] bp_hit", seg, k), 32'(bp_hit0), 32'(e[0]));
        end_cyc();
        k++;
      end
    end
  endtask

  task automatic probe_start();
    drive(C_NONE, 8'd0);
    @(negedge clk);
  endtask

  initial begin
    // seg 1: free run, halt_req in cycle 10
    for (int i = 1; i <= 17; i++)
      add(1, (i == 10) ? C_HALT : C_NONE, 8'd0, (i >= 14) ? E_HALT : ((i >= 11) ? E_FRZ : E_RUN));
    // seg 2: step 3 with a load-use stall
    add(2, C_STEP, 8'd3, E_HALT);
    add(2, C_NONE, 8'd0, E_RUN);
    add(2, C_HZ,   8'd0, E_RUN);
    add(2, C_NONE, 8'd0, E_RUN);
    add(2, C_NONE, 8'd0, E_RUN);
    for (int i = 0; i < 3; i++) add(2, C_NONE, 8'd0, E_FRZ);
    add(2, C_NONE, 8'd0, E_HALT);
    // seg 3: step count 0 behaves as 1
    add(3, C_STEP, 8'd0, E_HALT);
    add(3, C_NONE, 8'd0, E_RUN);
    for (int i = 0; i < 3; i++) add(3, C_NONE, 8'd0, E_FRZ);
    add(3, C_NONE, 8'd0, E_HALT);
    // seg 4: run into breakpoint at 0x40
    add(4, C_RUN,  8'd0, E_HALT);
    add(4, C_NONE, 8'd0, E_RUN);
    add(4, C_NONE, 8'd0, E_RUN);
    add(4, C_NONE, 8'd0, E_FRZ);
    for (int i = 0; i < 3; i++) add(4, C_NONE, 8'd0, E_BPD);
    add(4, C_NONE, 8'd0, E_BPH);
    // seg 5: resume past the breakpoint
    add(5, C_RUN, 8'd0, E_BPH);
    for (int i = 0; i < 4; i++) add(5, C_NONE, 8'd0, E_RUN);
    // seg 6: halt_req during two redirect cycles
    add(6, C_HALT | C_BR, 8'd0, E_RUN);
    add(6, C_BR,   8'd0, E_RUN);
    add(6, C_NONE, 8'd0, E_RUN);
    for (int i = 0; i < 3; i++) add(6, C_NONE, 8'd0, E_FRZ);
    add(6, C_NONE, 8'd0, E_HALT);
    // seg 7: triple request in HALT -> STEP of 2
    add(7, C_RUN | C_HALT | C_STEP, 8'd2, E_HALT);
    add(7, C_NONE, 8'd0, E_RUN);
    add(7, C_NONE, 8'd0, E_RUN);
    for (int i = 0; i < 3; i++) add(7, C_NONE, 8'd0, E_FRZ);
    add(7, C_NONE, 8'd0, E_HALT);
    // seg 8: triple request in RUN -> DRAIN
    add(8, C_RUN,  8'd0, E_HALT);
    add(8, C_NONE, 8'd0, E_RUN);
    add(8, C_RUN | C_HALT | C_STEP, 8'd5, E_RUN);
    for (int i = 0; i < 3; i++) add(8, C_NONE, 8'd0, E_FRZ);
    add(8, C_NONE, 8'd0, E_HALT);
    // seg 9: reset in the middle of DRAIN
    add(9, C_RUN,  8'd0, E_HALT);
    add(9, C_HALT, 8'd0, E_RUN);
    add(9, C_RST,  8'd0, E_FRZ);

    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; step_cnt = 8'd0;
    bp_en = 1'b0; bp_addr = BP_PC; br_sel_e = 1'b0; hz_stall = 1'b0; issue_vld = 1'b0;
    pc_d = 32'd0; pc_nxt = 32'd0; d_vld = 1'b0; fz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    probe_start();
    check("rst stall_f0", 32'(stall_f0), 32'd0);
    check("rst halted0", 32'(halted0), 32'd0);
    check("rst bp_hit0", 32'(bp_hit0), 32'd0);
    check("rst issue_cnt0", issue_cnt0, 32'd0);
    check("rst cycle_cnt0", cycle_cnt0, 32'd0);
    check("rst halted1", 32'(halted1), 32'd1);
    check("rst flush_e1", 32'(flush_e1), 32'd1);
    end_cyc();

    run_tab(1);
    probe_start();
    check("halt issued", n_iss, 32'd10);
    check("halt issue_cnt", issue_cnt0, PERF ? 32'd10 : 32'd0);
    check("halt cycle_cnt", cycle_cnt0, PERF ? 32'd11 : 32'd0);
    end_cyc();

    n0 = n_iss;
    run_tab(2);
    probe_start();
    check("step3 issued", n_iss - n0, 32'd3);
    check("step3 pc_d", pc_d, 32'h34);
    check("step3 issue_cnt", issue_cnt0, PERF ? 32'd13 : 32'd0);
    check("step3 cycle_cnt", cycle_cnt0, PERF ? 32'd15 : 32'd0);
    end_cyc();

    n0 = n_iss;
    run_tab(3);
    probe_start();
    check("step0 issued", n_iss - n0, 32'd1);
    check("step0 pc_d", pc_d, 32'h38);
    check("step0 issue_cnt", issue_cnt0, PERF ? 32'd14 : 32'd0);
    check("step0 cycle_cnt", cycle_cnt0, PERF ? 32'd16 : 32'd0);
    end_cyc();

    bp_en = 1'b1;
    run_tab(4);
    probe_start();
    check("bp held pc_d", pc_d, BP_PC);
    check("bp never issued", n_bp_iss, 32'd0);
    end_cyc();
    run_tab(5);
    probe_start();
    check("bp resume issued once", n_bp_iss, 32'd1);
    check("bp resume bp_hit", 32'(bp_hit0), 32'd0);
    end_cyc();
    bp_en = 1'b0;

    n0 = n_iss;
    run_tab(6);
    probe_start();
    check("redir issued", n_iss - n0, 32'd0);
    check("redir target kept", pc_d, BR_TGT);
    check("redir d_vld", 32'(d_vld), 32'd1);
    end_cyc();

    n0 = n_iss;
    run_tab(7);
    probe_start();
    check("triple halt step issued", n_iss - n0, 32'd2);
    end_cyc();

    run_tab(8);
    run_tab(9);
    probe_start();
    check("rst drain stall_f0", 32'(stall_f0), 32'd0);
    check("rst drain halted0", 32'(halted0), 32'd0);
    check("rst drain halted1", 32'(halted1), 32'd1);
    check("rst drain stall_f1", 32'(stall_f1), 32'd1);
    check("rst drain bp_hit1", 32'(bp_hit1), 32'd0);
    check("rst drain issue_cnt0", issue_cnt0, 32'd0);
    check("rst drain cycle_cnt0", cycle_cnt0, 32'd0);
    check("rst drain issue_cnt1", issue_cnt1, 32'd0);
    check("rst drain cycle_cnt1", cycle_cnt1, 32'd0);
    end_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
